// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one req/ack memory port between the F-stage instruction fetch (I) and
// the M-stage data access (D) of a 5-stage MIPS pipeline. D has priority; a
// launched transaction always runs to completion. Per-port done flags stay set
// until the pipeline advances (stall==0), so a served port is never re-issued
// while the other port still holds the pipe frozen.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   i_req/i_addr                fetch request and PC, held until i_ready
//   i_rdata/i_ready             registered instruction, served level
//   d_req/d_addr/d_wdata/d_byteen  data request (d_byteen==0 means load)
//   d_rdata/d_ready             registered load data, served level
//   stall                       combinational pipeline freeze request
//   mem_req/mem_addr/mem_wdata/mem_byteen  registered memory request
//   mem_rdata/mem_ack           memory response (ack may come in first cycle)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int MEM_AW = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic [31:0]       i_rdata,
    output logic              i_ready,
    input  logic              d_req,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [3:0]        d_byteen,
    output logic [31:0]       d_rdata,
    output logic              d_ready,
    output logic              stall,
    output logic              mem_req,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_byteen,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } state_e;

    state_e            state_q,      state_d;
    logic              mem_req_q,    mem_req_d;
    logic [MEM_AW-1:0] mem_addr_q,   mem_addr_d;
    logic [31:0]       mem_wdata_q,  mem_wdata_d;
    logic [3:0]        mem_byteen_q, mem_byteen_d;
    logic              i_done_q,     i_done_d;
    logic              d_done_q,     d_done_d;
    logic [31:0]       i_rdata_q,    i_rdata_d;
    logic [31:0]       d_rdata_q,    d_rdata_d;

    logic i_pending;
    logic d_pending;

    assign i_pending = i_req & ~i_done_q;
    assign d_pending = d_req & ~d_done_q;
    assign stall     = i_pending | d_pending;

    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_byteen_d = mem_byteen_q;
        i_done_d     = i_done_q;
        d_done_d     = d_done_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;

        // Pipeline advances: both steps' services are consumed. A completion
        // on this same edge (request dropped mid-flight) still sets its flag
        // below, because the set is applied after the clear.
        if (!stall) begin
            i_done_d = 1'b0;
            d_done_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                // A stray mem_ack here is ignored.
                if (d_pending) begin
                    state_d      = BUSY_D;
                    mem_req_d    = 1'b1;
                    mem_addr_d   = MEM_AW'(d_addr);
                    mem_wdata_d  = d_wdata;
                    mem_byteen_d = d_byteen;
                end else if (i_pending) begin
                    state_d      = BUSY_I;
                    mem_req_d    = 1'b1;
                    mem_addr_d   = MEM_AW'(i_addr);
                    mem_byteen_d = 4'b0000;
                end
            end
            BUSY_I: begin
                if (mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    i_done_d  = 1'b1;
                    i_rdata_d = mem_rdata;
                end
            end
            BUSY_D: begin
                if (mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    d_done_d  = 1'b1;
                    // Stores leave the last load result visible.
                    if (mem_byteen_q == 4'b0000) begin
                        d_rdata_d = mem_rdata;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_byteen_q <= '0;
            i_done_q     <= 1'b0;
            d_done_q     <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_byteen_q <= mem_byteen_d;
            i_done_q     <= i_done_d;
            d_done_q     <= d_done_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_byteen = mem_byteen_q;
    assign i_ready    = i_done_q;
    assign d_ready    = d_done_q;
    assign i_rdata    = i_rdata_q;
    assign d_rdata    = d_rdata_q;

endmodule
